// File: rtl/bl_wl_config_driver_if.sv
// Bitstream word stream into the bl/wl configuration driver.
// Master is the bitstream source; slave is the driver.
interface bl_wl_config_driver_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bl_wl_config_driver.sv
// Memory-bank configuration driver: assembles BL_WIDTH-bit rows from a word stream and strobes one wordline per row.
// Optional trailer checksum is enabled with `define BL_WL_CONFIG_DRIVER_CHECKSUM_EN.
module bl_wl_config_driver #(
    parameter int BL_WIDTH        = 40,
    parameter int WL_WIDTH        = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int SETUP_CYCLES    = 1,
    parameter int WL_PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic                   prog_clk,
    input  logic                   prog_reset_n,
    input  logic                   start,
    input  logic                   abort,
    bl_wl_config_driver_if.slave   in_if,
    output logic [BL_WIDTH-1:0]    bl_out,
    output logic [WL_WIDTH-1:0]    wl_out,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int WORDS   = BL_WIDTH / DATA_WIDTH;
    localparam int WIDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int ROW_W   = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int CNT_MAX = (SETUP_CYCLES > WL_PULSE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((WL_PULSE_CYCLES > HOLD_CYCLES) ? WL_PULSE_CYCLES : HOLD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // True on the last cycle of a phase lasting len cycles.
    function automatic logic cnt_last(input logic [CNT_W-1:0] cnt, input int len);
        return (cnt == CNT_W'(len - 1));
    endfunction

    // Running checksum fold of one accepted word into the accumulator.
    function automatic logic [DATA_WIDTH-1:0] xor_fold(input logic [DATA_WIDTH-1:0] acc,
                                                        input logic [DATA_WIDTH-1:0] word);
        return acc ^ word;
    endfunction

    logic [2:0]            state_q,    state_d;
    logic [ROW_W-1:0]      row_q,      row_d;
    logic [WIDX_W-1:0]     widx_q,     widx_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [BL_WIDTH-1:0]   bl_q,       bl_d;
    logic [WL_WIDTH-1:0]   wl_q,       wl_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  xfer_s;
    logic                  begin_s;
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_q,      xor_d;
    logic                  cfg_err_q,  cfg_err_d;
`endif

    // Next-state and next-output computation; outputs are derived from state_d so they register with the state.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        widx_d  = widx_q;
        cnt_d   = cnt_q;
        bl_d    = bl_q;
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
        xor_d     = xor_q;
        cfg_err_d = cfg_err_q;
`endif
        xfer_s  = in_if.in_valid && in_ready_q;
        begin_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    bl_d[widx_q*DATA_WIDTH +: DATA_WIDTH] = in_if.in_data;
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
                    xor_d = xor_fold(xor_q, in_if.in_data);
`endif
                    if (widx_q == WIDX_W'(WORDS - 1)) begin
                        widx_d  = {WIDX_W{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_SETUP;
                    end else begin
                        widx_d  = widx_q + WIDX_W'(1);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_last(cnt_q, SETUP_CYCLES)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_PULSE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_last(cnt_q, WL_PULSE_CYCLES)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_last(cnt_q, HOLD_CYCLES)) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (row_q == ROW_W'(WL_WIDTH - 1)) begin
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer_s) begin
                    cfg_err_d = (in_if.in_data != xor_q);
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_CHECK;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (begin_s) begin
            row_d  = {ROW_W{1'b0}};
            widx_d = {WIDX_W{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
            xor_d     = {DATA_WIDTH{1'b0}};
            cfg_err_d = 1'b0;
`endif
        end else begin
            row_d = row_d;
        end

        // Abort wins over every transition and throws away any half-loaded row.
        if (abort) begin
            state_d = S_IDLE;
            row_d   = {ROW_W{1'b0}};
            widx_d  = {WIDX_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
            cfg_err_d = 1'b0;
`endif
        end else begin
            state_d = state_d;
        end

        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            bl_d = {BL_WIDTH{1'b0}};
        end else begin
            bl_d = bl_d;
        end

        if (state_d == S_PULSE) begin
            wl_d = {{(WL_WIDTH-1){1'b0}}, 1'b1} << row_d;
        end else begin
            wl_d = {WL_WIDTH{1'b0}};
        end

        in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= S_IDLE;
            row_q      <= {ROW_W{1'b0}};
            widx_q     <= {WIDX_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            bl_q       <= {BL_WIDTH{1'b0}};
            wl_q       <= {WL_WIDTH{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            widx_q     <= widx_d;
            cnt_q      <= cnt_d;
            bl_q       <= bl_d;
            wl_q       <= wl_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
    // Checksum accumulator and latched mismatch flag.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            xor_q     <= {DATA_WIDTH{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    assign bl_out         = bl_q;
    assign wl_out         = wl_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign in_if.in_ready = in_ready_q;

endmodule

// File: tb/tb_bl_wl_config_driver.sv
// Self-checking bench for bl_wl_config_driver: directed passes with random data against a row/pulse reference model.
module tb_bl_wl_config_driver;

    localparam int BLW   = 40;
    localparam int WLW   = 4;
    localparam int DW    = 8;
    localparam int SC    = 1;
    localparam int PC    = 2;
    localparam int HC    = 1;
    localparam int WORDS = BLW / DW;
    localparam int NW    = WORDS * WLW;
    localparam int LIMIT = 2000;
`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic            prog_clk = 1'b0;
    logic            prog_reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [BLW-1:0]  bl_out;
    logic [WLW-1:0]  wl_out;
    logic            busy, done, cfg_err;

    int n_chk  = 0;
    int n_fail = 0;
    int pass_cycles;

    logic [DW-1:0]  stream[$];
    logic [WLW-1:0] pw[$];
    logic [BLW-1:0] pb[$];

    bl_wl_config_driver_if #(.DATA_WIDTH(DW)) in_if ();

    bl_wl_config_driver #(
        .BL_WIDTH(BLW), .WL_WIDTH(WLW), .DATA_WIDTH(DW),
        .SETUP_CYCLES(SC), .WL_PULSE_CYCLES(PC), .HOLD_CYCLES(HC)
    ) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
        .start(start), .abort(abort), .in_if(in_if),
        .bl_out(bl_out), .wl_out(wl_out),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Builds a pass worth of words (plus checksum trailer when the feature is built in).
    task automatic make_stream(input bit incr, input bit bad_trailer);
        logic [DW-1:0] w;
        logic [DW-1:0] x;
        x = '0;
        stream.delete();
        for (int i = 0; i < NW; i++) begin
            w = incr ? DW'(i + 1) : DW'($urandom);
            stream.push_back(w);
            x = x ^ w;
        end
        if (CK == 1) stream.push_back(bad_trailer ? (x ^ 8'h01) : x);
    endtask

    function automatic logic [BLW-1:0] row_model(input int r);
        logic [BLW-1:0] e;
        e = '0;
        for (int k = 0; k < WORDS; k++) e[k*DW +: DW] = stream[r*WORDS + k];
        return e;
    endfunction

    // Checks the recorded wordline pulses: rows in order, each exactly PC cycles, carrying that row's data.
    task automatic check_pulses(input int n_expected);
        chk("pulse_count", 64'(pw.size()), 64'(n_expected));
        for (int i = 0; i < pw.size() && i < n_expected; i++) begin
            chk("pulse_wl", 64'(pw[i]), 64'(1 << (i / PC)));
            chk("pulse_bl", 64'(pb[i]), 64'(row_model(i / PC)));
        end
    endtask

    // Runs one pass: mode 0 valid always, 1 alternating, 2 random; optional abort at a row's pulse and a start while busy.
    task automatic run_pass(input int mode, input int abort_row, input int busy_start_cyc);
        int idx;
        bit pend;
        bit finished;
        logic [BLW-1:0] prev_bl;
        logic [WLW-1:0] prev_wl;
        idx = 0; pend = 1'b0; finished = 1'b0;
        pw.delete(); pb.delete();
        prev_bl = bl_out; prev_wl = '0;
        @(negedge prog_clk);
        start = 1'b1;
        in_if.in_valid = 1'b0;
        for (int cyc = 1; cyc <= LIMIT && !finished; cyc++) begin
            @(negedge prog_clk);
            start = (cyc == busy_start_cyc);
            if (cyc == 1) begin
                chk("start_done_low", 64'(done), 64'(0));
                chk("start_busy", 64'(busy), 64'(1));
            end
            if (wl_out != '0) begin
                chk("wl_onehot", 64'($countones(wl_out)), 64'(1));
                chk("bl_stable_pulse", 64'(bl_out), 64'(prev_bl));
                chk("ready_low_pulse", 64'(in_if.in_ready), 64'(0));
                pw.push_back(wl_out); pb.push_back(bl_out);
                if (abort_row >= 0 && wl_out == WLW'(1 << abort_row)) begin
                    abort = 1'b1;
                    in_if.in_valid = 1'b0;
                    @(negedge prog_clk);
                    abort = 1'b0;
                    chk("abort_wl", 64'(wl_out), 64'(0));
                    chk("abort_bl", 64'(bl_out), 64'(0));
                    chk("abort_done", 64'(done), 64'(0));
                    chk("abort_busy", 64'(busy), 64'(0));
                    pass_cycles = cyc;
                    return;
                end
            end else if (prev_wl != '0) begin
                chk("bl_stable_hold", 64'(bl_out), 64'(prev_bl));
            end
            if (done) begin
                chk("done_wl", 64'(wl_out), 64'(0));
                chk("done_bl", 64'(bl_out), 64'(0));
                chk("done_ready", 64'(in_if.in_ready), 64'(0));
                chk("done_busy", 64'(busy), 64'(0));
                chk("words_used", 64'(idx + (pend ? 1 : 0)), 64'(stream.size()));
                pass_cycles = cyc;
                finished = 1'b1;
            end else begin
                if (pend) idx++;
                case (mode)
                    0:       in_if.in_valid = (idx < stream.size());
                    1:       in_if.in_valid = (idx < stream.size()) && (cyc % 2 == 0);
                    default: in_if.in_valid = (idx < stream.size()) && ($urandom_range(1, 0) == 1);
                endcase
                in_if.in_data = (idx < stream.size()) ? stream[idx] : '0;
                pend = in_if.in_valid && in_if.in_ready;
                prev_bl = bl_out;
                prev_wl = wl_out;
            end
        end
        in_if.in_valid = 1'b0;
        if (!finished) chk("pass_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        repeat (3) @(negedge prog_clk);
        chk("rst_bl", 64'(bl_out), 64'(0));
        chk("rst_wl", 64'(wl_out), 64'(0));
        chk("rst_ready", 64'(in_if.in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        // Incrementing words, valid held high, a start pulse while busy in row 1.
        make_stream(1'b1, 1'b0);
        run_pass(0, -1, 12);
        check_pulses(WLW * PC);
        chk("row0_value", 64'(pb[0]), 64'h0504030201);
        chk("pass_latency", 64'(pass_cycles), 64'(WLW * (WORDS + SC + PC + HC) + 1 + CK));
        chk("pass_done", 64'(done), 64'(1));
        chk("pass_cfg_err", 64'(cfg_err), 64'(0));

        // Same stream from DONE with valid toggling.
        run_pass(1, -1, -1);
        check_pulses(WLW * PC);
        chk("toggle_cfg_err", 64'(cfg_err), 64'(0));

        // Abort in the pulse of row 2, then a fresh pass from row 0.
        make_stream(1'b0, 1'b0);
        run_pass(0, 2, -1);
        check_pulses(2 * PC + 1);
        make_stream(1'b0, 1'b0);
        run_pass(2, -1, -1);
        check_pulses(WLW * PC);

        // Asynchronous reset between edges while loading; start ignored under reset.
        make_stream(1'b0, 1'b0);
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = stream[0];
        repeat (2) @(negedge prog_clk);
        #2 prog_reset_n = 1'b0;
        #1;
        chk("arst_bl", 64'(bl_out), 64'(0));
        chk("arst_wl", 64'(wl_out), 64'(0));
        chk("arst_ready", 64'(in_if.in_ready), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        start = 1'b1;
        in_if.in_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        chk("arst_start_ignored", 64'(busy), 64'(0));
        start = 1'b0;
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        chk("arst_release_idle", 64'(busy), 64'(0));

`ifdef BL_WL_CONFIG_DRIVER_CHECKSUM_EN
        // Wrong trailer must flag a checksum error alongside done.
        make_stream(1'b1, 1'b1);
        run_pass(0, -1, -1);
        check_pulses(WLW * PC);
        chk("ck_bad_err", 64'(cfg_err), 64'(1));
        chk("ck_bad_done", 64'(done), 64'(1));
`endif

        // Random data and handshake patterns.
        for (int p = 0; p < 3; p++) begin
            make_stream(1'b0, 1'b0);
            run_pass(p, -1, -1);
            check_pulses(WLW * PC);
            chk("rand_cfg_err", 64'(cfg_err), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
